gray_seq_ctrl: RTL and testbench
================================

Name: gray_seq_ctrl

Overview:
Sequencer that steps a binary count through the team's 4-bit binary-to-Gray encoding and streams the resulting Gray codes to a consumer over a valid/ready handshake. It supports up/down direction, single-shot or wrap-around mode, start/stop control, and done/wrap status pulses. It sits between a control register block and any consumer needing a Gray sequence, such as a position encoder model or a pointer-exchange test driver.

Parameters:
WIDTH, 4, bit width of count and Gray code
LAST, 15, terminal binary count; legal range 1..2**WIDTH-1

Ports:
clk  in  1  single system clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  begin a sequence; sampled only in IDLE
stop  in  1  abort the running sequence
dir  in  1  0=up (0..LAST), 1=down (LAST..0); sampled at start
wrap_en  in  1  1=restart at wrap; 0=single-shot; sampled at start
out_ready  in  1  consumer ready
out_valid  out  1  gray_out valid
gray_out  out  WIDTH  Gray code of current count, registered
bin_out  out  WIDTH  current binary count, registered
busy  out  1  high in EMIT
done  out  1  one-cycle pulse at single-shot completion
wrap  out  1  one-cycle pulse when count wraps

Behaviour:
- Reset: synchronous, active-high. All outputs are 0, state=IDLE, count=0, latched dir/wrap_en=0. Reset mid-sequence forces this state on the next edge, with no done or wrap pulse.
- Gray rule: gray = bin ^ (bin >> 1). gray_out and bin_out update on the same edge as count.
- States: IDLE, EMIT, DONE.
- IDLE: out_valid=0, busy=0. If start=1 and stop=0, latch dir and wrap_en, load count = (dir ? LAST : 0), and go to EMIT. out_valid rises on the edge after start (1-cycle latency).
- EMIT: out_valid=1 and busy=1.
  - Transfer occurs when out_valid and out_ready are both high.
  - No transfer: gray_out and bin_out are held stable.
  - Transfer at a non-terminal count: count +1 (up) or -1 (down).
  - Terminal count is LAST for up and 0 for down.
  - Transfer at terminal with wrap_en=1: count reloads the start value, wrap=1 for one cycle, stay in EMIT.
  - Transfer at terminal with wrap_en=0: go to DONE.
- DONE: out_valid=0; done=1 for exactly one cycle; go to IDLE next cycle.
- Stop: stop=1 in EMIT goes to IDLE next edge with out_valid=0.
  - A transfer in the same cycle still counts as completed.
  - No done or wrap pulse, even if at terminal.
  - Stop is the only permitted case of out_valid dropping without a transfer.
- Simultaneous events:
  - start and stop together in IDLE: stop wins, stay in IDLE.
  - start in EMIT or DONE: ignored.
  - dir and wrap_en changes mid-sequence: ignored.
- Back-to-back: start accepted on the IDLE cycle following DONE. Minimum gap between sequences is 2 cycles.
- Throughput: with out_ready held high, one code per cycle.
- Width: count arithmetic is WIDTH bits. With LAST=2**WIDTH-1, wrap-around reloads explicitly rather than relying on overflow.

Decomposition:
- Package gray_seq_pkg:
  - state_t enum {IDLE, EMIT, DONE}
  - DIR_UP/DIR_DOWN constants
  - function bin_to_gray(logic [WIDTH-1:0])
- One natural sub-module: gray_encode, a combinational WIDTH-bit binary-to-Gray encoder instantiated on next-count before the output register.
- The FSM and counter stay in gray_seq_ctrl.

Test Plan:
1. LAST=15, dir=0, wrap_en=0, out_ready=1, start pulse -> out_valid for 16 cycles, gray_out sequence 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8; then done=1 for one cycle, busy=0, state IDLE.
2. Backpressure: out_ready=0 for 3 cycles while gray_out=3 (bin 2) -> gray_out=3 and bin_out=2 stable for those 3 cycles; after out_ready=1 the next value is gray 2 (bin 3), with no codes skipped or duplicated.
3. dir=1, wrap_en=1, out_ready=1 -> gray 8,9,B,A,...,1,0; then wrap=1 for one cycle and gray_out=8 (bin 15) again; done is never asserted.
4. stop at bin 5 (gray 7) with out_ready=0 -> next cycle out_valid=0, busy=0, done=0; the following start restarts from bin 0.
5. rst=1 mid-sequence at bin 9 -> next edge all outputs 0; start asserted during EMIT has no effect on count; start and stop together in IDLE stays in IDLE.
6. LAST=9, dir=0, wrap_en=0 -> final code gray 1101 (bin 9), then done; with dir=1 the first code is gray 1101 and the last is 0000.

Source files
------------

// File: rtl/gray_seq_pkg.sv
// gray_seq_pkg: shared types, direction constants and Gray helper for the Gray sequencer
package gray_seq_pkg;
    localparam int DEF_WIDTH = 4;
    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [DEF_WIDTH-1:0] bin_to_gray(input logic [DEF_WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction
endpackage

// File: rtl/gray_seq_ctrl_if.sv
// gray_seq_ctrl_if: valid/ready stream of Gray codes with the matching binary count
interface gray_seq_ctrl_if
    import gray_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] gray_out;
    logic [WIDTH-1:0] bin_out;

    modport master(output out_valid, gray_out, bin_out, input out_ready);
    modport slave(input out_valid, gray_out, bin_out, output out_ready);
endinterface

// File: rtl/gray_seq_ctrl_gray_encode.sv
// gray_encode: combinational binary-to-Gray encoder
module gray_encode
    import gray_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);
    assign gray = bin ^ (bin >> 1);
endmodule

// File: rtl/gray_seq_ctrl.sv
// gray_seq_ctrl: up/down, single-shot or wrapping Gray sequencer streaming over valid/ready
module gray_seq_ctrl
    import gray_seq_pkg::*;
#(
    parameter int               WIDTH = DEF_WIDTH,
    parameter logic [WIDTH-1:0] LAST  = WIDTH'(15)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              dir,
    input  logic              wrap_en,
    gray_seq_ctrl_if.master   bus,
    output logic              busy,
    output logic              done,
    output logic              wrap
);
    state_t           st, ns;
    logic             dir_q, wrap_q, nwrap, xfer, term, go;
    logic [WIDTH-1:0] cnt, nc, ng, first;

    assign cnt   = bus.bin_out;
    assign xfer  = bus.out_valid && bus.out_ready;
    assign first = (dir_q == DIR_DOWN) ? LAST : '0;
    assign term  = (dir_q == DIR_DOWN) ? (cnt == '0) : (cnt == LAST);
    assign go    = (st == IDLE) && start && !stop;

    // The terminal transfer reloads explicitly so LAST = 2**WIDTH-1 never relies on overflow
    always_comb begin
        ns    = st;
        nc    = cnt;
        nwrap = 1'b0;
        if (go) begin
            ns = EMIT;
            nc = (dir == DIR_DOWN) ? LAST : '0;
        end else if (st == EMIT) begin
            if (xfer) begin
                nc    = term ? (wrap_q ? first : cnt) : ((dir_q == DIR_DOWN) ? cnt - WIDTH'(1) : cnt + WIDTH'(1));
                nwrap = term && wrap_q && !stop;
                ns    = (term && !wrap_q) ? DONE : EMIT;
            end
            if (stop) ns = IDLE;
        end else if (st == DONE) begin
            ns = IDLE;
        end
    end

    gray_encode #(.WIDTH(WIDTH)) u_enc (.bin(nc), .gray(ng));

    always_ff @(posedge clk) begin
        if (rst) begin
            st            <= IDLE;
            bus.bin_out   <= '0;
            bus.gray_out  <= '0;
            bus.out_valid <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            wrap          <= 1'b0;
            dir_q         <= 1'b0;
            wrap_q        <= 1'b0;
        end else begin
            st            <= ns;
            bus.bin_out   <= nc;
            bus.gray_out  <= ng;
            bus.out_valid <= ns == EMIT;
            busy          <= ns == EMIT;
            done          <= ns == DONE;
            wrap          <= nwrap;
            if (go) begin
                dir_q  <= dir;
                wrap_q <= wrap_en;
            end
        end
    end
endmodule

// File: tb/tb_gray_seq_ctrl.sv
// tb_gray_seq_ctrl: directed and random stimulus against a position-based reference model
module tb_gray_seq_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1, start = 1'b0, stop = 1'b0, dir = 1'b0, wrap_en = 1'b0, ready = 1'b0;
    logic busy0, done0, wrap0, busy1, done1, wrap1;
    int compared = 0, mismatched = 0;

    int phase[2], pos[2];
    bit mdir[2], mwrap[2], edone[2], ewrap[2];
    int lastv[2] = '{15, 9};

    always #5 clk = ~clk;

    gray_seq_ctrl_if #(.WIDTH(4)) b0 ();
    gray_seq_ctrl_if #(.WIDTH(4)) b1 ();
    assign b0.out_ready = ready;
    assign b1.out_ready = ready;

    gray_seq_ctrl #(.WIDTH(4), .LAST(4'd15)) dut0 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .dir(dir), .wrap_en(wrap_en),
        .bus(b0), .busy(busy0), .done(done0), .wrap(wrap0)
    );
    gray_seq_ctrl #(.WIDTH(4), .LAST(4'd9)) dut1 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .dir(dir), .wrap_en(wrap_en),
        .bus(b1), .busy(busy1), .done(done1), .wrap(wrap1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // phase: 0 idle, 1 emitting, 2 done; pos counts transfers from the sequence start
    task automatic model(input int i);
        edone[i] = 1'b0;
        ewrap[i] = 1'b0;
        if (rst) begin
            phase[i] = 0; pos[i] = 0; mdir[i] = 1'b0; mwrap[i] = 1'b0;
        end else if (phase[i] == 1) begin
            if (ready) begin
                if (pos[i] == lastv[i]) begin
                    if (mwrap[i]) begin
                        pos[i] = 0;
                        ewrap[i] = !stop;
                    end else phase[i] = 2;
                end else pos[i]++;
            end
            if (stop) phase[i] = 0;
        end else if (phase[i] == 2) begin
            phase[i] = 0;
        end else if (start && !stop) begin
            phase[i] = 1; pos[i] = 0; mdir[i] = dir; mwrap[i] = wrap_en;
        end
        edone[i] = phase[i] == 2;
    endtask

    task automatic cmp(input int i, input logic v, input logic b, input logic d, input logic w,
                       input logic [3:0] bn, input logic [3:0] g);
        int eb;
        eb = mdir[i] ? lastv[i] - pos[i] : pos[i];
        check($sformatf("valid%0d", i), 32'(v), 32'(phase[i] == 1));
        check($sformatf("busy%0d", i), 32'(b), 32'(phase[i] == 1));
        check($sformatf("done%0d", i), 32'(d), 32'(edone[i]));
        check($sformatf("wrap%0d", i), 32'(w), 32'(ewrap[i]));
        check($sformatf("bin%0d", i), 32'(bn), 32'(eb));
        check($sformatf("gray%0d", i), 32'(g), 32'(eb ^ (eb >> 1)));
    endtask

    task automatic step();
        @(posedge clk);
        model(0);
        model(1);
        #1;
        cmp(0, b0.out_valid, busy0, done0, wrap0, b0.bin_out, b0.gray_out);
        cmp(1, b1.out_valid, busy1, done1, wrap1, b1.bin_out, b1.gray_out);
    endtask

    initial begin
        step();
        rst = 1'b0; ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        repeat (20) step();
        dir = 1'b1; wrap_en = 1'b1; start = 1'b1;
        step();
        start = 1'b0; dir = 1'b0; wrap_en = 1'b0;
        repeat (3) step();
        ready = 1'b0;
        repeat (3) step();
        ready = 1'b1;
        repeat (36) step();
        stop = 1'b1;
        step();
        stop = 1'b0; start = 1'b1;
        step();
        stop = 1'b1;
        step();
        stop = 1'b0; start = 1'b0;
        repeat (4) step();
        for (int n = 0; n < 4000; n++) begin
            rst     = ($urandom_range(0, 149) == 0);
            start   = ($urandom_range(0, 3) == 0);
            stop    = ($urandom_range(0, 24) == 0);
            dir     = 1'($urandom);
            wrap_en = 1'($urandom);
            ready   = ($urandom_range(0, 3) != 0);
            step();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
